// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Module      : config_pkg
// Description : fdivsqrt datapath configuration shared by all blocks.
//               DIVb : number of fractional quotient/root bits; operands
//                      handled by the digit generator are DIVb+1 bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;
  localparam int unsigned DIVb = 10;
endpackage
`default_nettype wire

// File: rtl/fdivsqrt_digitgen4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdivsqrt_digitgen4_pkg
// Description : Shared radix-4 digit definitions for the fdivsqrt digit
//               generator and on-the-fly converter: one-hot udigit codes,
//               derived widths and the generator state type.
// Revision    : 1.0 - initial release
// ============================================================================
package fdivsqrt_digitgen4_pkg;
  import config_pkg::*;

  localparam int unsigned OPW   = DIVb + 1;          // operand width
  localparam int unsigned ND    = (DIVb + 3) / 2;    // digits per operand
  localparam int unsigned XW    = 2 * ND + 1;        // extended operand width
  localparam int unsigned CNT_W = (ND > 1) ? $clog2(ND) : 1;

  // One-hot digit encoding, identical to what the converter decodes.
  localparam logic [3:0] UD_P2   = 4'b1000;
  localparam logic [3:0] UD_P1   = 4'b0100;
  localparam logic [3:0] UD_M1   = 4'b0010;
  localparam logic [3:0] UD_M2   = 4'b0001;
  localparam logic [3:0] UD_ZERO = 4'b0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/fdivsqrt_digitgen4_if.sv
`default_nettype none
// ============================================================================
// Module      : fdivsqrt_digitgen4_if
// Description : Operand load and digit stream bundle of the digit generator.
//   flush     : synchronous abort (master -> slave)
//   in_valid  : operand X offered       in_ready : operand accepted
//   X         : DIVb+1 bit operand
//   out_valid : digit presented         out_ready: digit consumed
//   udigit    : one-hot digit           C        : position mask
//   out_last  : least-significant digit of the operand
// Revision    : 1.0 - initial release
// ============================================================================
interface fdivsqrt_digitgen4_if;
  import config_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DIVb:0]   X;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      udigit;
  logic [DIVb:0]   C;
  logic            out_last;

  modport master (
    output flush, in_valid, X, out_ready,
    input  in_ready, out_valid, udigit, C, out_last
  );

  modport slave (
    input  flush, in_valid, X, out_ready,
    output in_ready, out_valid, udigit, C, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fdivsqrt_booth4enc.sv
`default_nettype none
// ============================================================================
// Module      : fdivsqrt_booth4enc
// Description : Combinational radix-4 Booth recoder. Maps an overlapping
//               bit triple to the digit d = -2*b2 + b1 + b0 in one-hot form.
//   i_b2, i_b1, i_b0 : bit triple, i_b2 most significant
//   o_udigit         : one-hot digit, 0000 for zero
// Revision    : 1.0 - initial release
// ============================================================================
module fdivsqrt_booth4enc
  import fdivsqrt_digitgen4_pkg::*;
(
  input  logic       i_b2,
  input  logic       i_b1,
  input  logic       i_b0,
  output logic [3:0] o_udigit
);

  always_comb begin
    o_udigit = UD_ZERO;
    case ({i_b2, i_b1, i_b0})
      3'b001, 3'b010: o_udigit = UD_P1;
      3'b011:         o_udigit = UD_P2;
      3'b100:         o_udigit = UD_M2;
      3'b101, 3'b110: o_udigit = UD_M1;
      default:        o_udigit = UD_ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fdivsqrt_digitgen4.sv
`default_nettype none
// ============================================================================
// Module      : fdivsqrt_digitgen4
// Description : Radix-4 signed-digit generator. Loads an unsigned operand
//               and streams it MSB-first as Booth digits in {-2..+2}, one
//               per handshake, together with the converter's C mask.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of fdivsqrt_digitgen4_if (load + digit stream)
// Revision    : 1.0 - initial release
// ============================================================================
module fdivsqrt_digitgen4
  import config_pkg::*;
  import fdivsqrt_digitgen4_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  fdivsqrt_digitgen4_if.slave   bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [XW-1:0]      r_xe;
  logic [CNT_W-1:0]   r_cnt;
  logic [OPW-1:0]     r_c;
  logic [3:0]         w_enc;
  logic               w_run;
  logic               w_last;
  logic               w_load;
  logic               w_adv;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_cnt == '0);
  assign w_load = (r_state == ST_IDLE) && bus.in_valid && !bus.flush;
  assign w_adv  = w_run && bus.out_ready && !bus.flush;

  // The current digit always sits in the top three bits of the shifted operand.
  fdivsqrt_booth4enc u_enc (
    .i_b2     (r_xe[XW-1]),
    .i_b1     (r_xe[XW-2]),
    .i_b0     (r_xe[XW-3]),
    .o_udigit (w_enc)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything, including a load.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)              w_state_nxt = ST_RUN;
      ST_RUN:  if (bus.out_ready && w_last)   w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
    if (bus.flush) w_state_nxt = ST_IDLE;
  end

  // Operand shifter, digit counter and C mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xe  <= '0;
      r_cnt <= '0;
      r_c   <= '0;
    end else if (w_load) begin
      // Zero-extended {X, x[-1]=0}; the top pad keeps the MSB digit positive.
      r_xe  <= XW'({bus.X, 1'b0});
      r_cnt <= CNT_W'(ND - 1);
      r_c   <= {2'b11, {(OPW-2){1'b0}}};
    end else if (w_adv && !w_last) begin
      r_xe  <= r_xe << 2;
      r_cnt <= r_cnt - 1'b1;
      r_c   <= {2'b11, r_c[OPW-1:2]};
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE);
    bus.out_valid = w_run;
    bus.out_last  = w_last;
    bus.udigit    = w_run ? w_enc : UD_ZERO;
    bus.C         = r_c;
  end

  a_udigit_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(bus.udigit));

endmodule
`default_nettype wire
